// File: rtl/register_file_scoreboard.sv
// Parametrised CPU register file with optional hardwired-zero R0, write-to-read
// bypass, and a per-register busy scoreboard that drives the decode stall.
module register_file_scoreboard #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 2,
    parameter int ZERO_REG0  = 0,
    parameter int BYPASS     = 1
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic [ADDR_WIDTH-1:0]      RS,
    input  logic [ADDR_WIDTH-1:0]      RT,
    output logic [DATA_WIDTH-1:0]      ReadRS,
    output logic [DATA_WIDTH-1:0]      ReadRT,
    input  logic [ADDR_WIDTH-1:0]      RD,
    input  logic [DATA_WIDTH-1:0]      WriteData,
    input  logic                       RegWrite,
    input  logic                       Reserve,
    input  logic [ADDR_WIDTH-1:0]      ReserveAddr,
    output logic                       Stall,
    output logic [2**ADDR_WIDTH-1:0]   BusyVec
);

    localparam int NUM_REGS = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   busy;

    logic write_en, reserve_en;
    logic fwd_rs, fwd_rt, zero_rs, zero_rt;

    assign write_en   = RegWrite && !(ZERO_REG0 != 0 && RD == '0);
    assign reserve_en = Reserve  && !(ZERO_REG0 != 0 && ReserveAddr == '0);

    // Forwarding is suppressed during reset so every read port shows 0 then.
    assign fwd_rs  = (BYPASS != 0) && RegWrite && !Reset && (RD == RS);
    assign fwd_rt  = (BYPASS != 0) && RegWrite && !Reset && (RD == RT);
    assign zero_rs = (ZERO_REG0 != 0) && (RS == '0);
    assign zero_rt = (ZERO_REG0 != 0) && (RT == '0);

    // NOTE: the array itself is reset because the contents must read 0 the
    // moment Reset rises, so it maps to flops rather than a RAM macro.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            busy <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (write_en) begin
                regs[RD] <= WriteData;
                busy[RD] <= 1'b0;
            end
            // NOTE: with non-blocking assignments the last one in program order
            // wins, so a same-address reserve overrides the write's busy clear.
            if (reserve_en) begin
                busy[ReserveAddr] <= 1'b1;
            end
        end
    end

    always_comb begin
        if (zero_rs)     ReadRS = '0;
        else if (fwd_rs) ReadRS = WriteData;
        else             ReadRS = regs[RS];
    end

    always_comb begin
        if (zero_rt)     ReadRT = '0;
        else if (fwd_rt) ReadRT = WriteData;
        else             ReadRT = regs[RT];
    end

    assign Stall   = (busy[RS] && !fwd_rs) || (busy[RT] && !fwd_rt);
    assign BusyVec = busy;

endmodule

// File: tb/tb_register_file_scoreboard.sv
// Bench for register_file_scoreboard: four parameter variants share one stimulus
// stream and are compared against an array-based reference model.
module tb_register_file_scoreboard;

    localparam int NC = 4;
    // variant: 0 = 16b/4 regs bypass, 1 = no bypass, 2 = zero R0, 3 = 32b/8 regs
    localparam int AWC [NC] = '{2, 2, 2, 3};
    localparam int DWC [NC] = '{16, 16, 16, 32};
    localparam int ZC  [NC] = '{0, 0, 1, 0};
    localparam int BC  [NC] = '{1, 0, 1, 1};

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  rs, rt, rd, ra;
    logic [31:0] wd;
    logic        we, res;

    always #5 clock = ~clock;

    wire [15:0] rs0, rt0, rs1, rt1, rs2, rt2;
    wire [31:0] rs3, rt3;
    wire        st0, st1, st2, st3;
    wire [3:0]  bv0, bv1, bv2;
    wire [7:0]  bv3;

    register_file_scoreboard #(.DATA_WIDTH(16), .ADDR_WIDTH(2), .ZERO_REG0(0), .BYPASS(1)) d0 (
        .Clock(clock), .Reset(reset), .RS(rs[1:0]), .RT(rt[1:0]), .ReadRS(rs0), .ReadRT(rt0),
        .RD(rd[1:0]), .WriteData(wd[15:0]), .RegWrite(we), .Reserve(res), .ReserveAddr(ra[1:0]),
        .Stall(st0), .BusyVec(bv0));
    register_file_scoreboard #(.DATA_WIDTH(16), .ADDR_WIDTH(2), .ZERO_REG0(0), .BYPASS(0)) d1 (
        .Clock(clock), .Reset(reset), .RS(rs[1:0]), .RT(rt[1:0]), .ReadRS(rs1), .ReadRT(rt1),
        .RD(rd[1:0]), .WriteData(wd[15:0]), .RegWrite(we), .Reserve(res), .ReserveAddr(ra[1:0]),
        .Stall(st1), .BusyVec(bv1));
    register_file_scoreboard #(.DATA_WIDTH(16), .ADDR_WIDTH(2), .ZERO_REG0(1), .BYPASS(1)) d2 (
        .Clock(clock), .Reset(reset), .RS(rs[1:0]), .RT(rt[1:0]), .ReadRS(rs2), .ReadRT(rt2),
        .RD(rd[1:0]), .WriteData(wd[15:0]), .RegWrite(we), .Reserve(res), .ReserveAddr(ra[1:0]),
        .Stall(st2), .BusyVec(bv2));
    register_file_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .ZERO_REG0(0), .BYPASS(1)) d3 (
        .Clock(clock), .Reset(reset), .RS(rs), .RT(rt), .ReadRS(rs3), .ReadRT(rt3),
        .RD(rd), .WriteData(wd), .RegWrite(we), .Reserve(res), .ReserveAddr(ra),
        .Stall(st3), .BusyVec(bv3));

    logic [31:0] a_rs [NC];
    logic [31:0] a_rt [NC];
    logic        a_st [NC];
    logic [7:0]  a_bv [NC];

    assign a_rs[0] = {16'h0, rs0};  assign a_rt[0] = {16'h0, rt0};
    assign a_rs[1] = {16'h0, rs1};  assign a_rt[1] = {16'h0, rt1};
    assign a_rs[2] = {16'h0, rs2};  assign a_rt[2] = {16'h0, rt2};
    assign a_rs[3] = rs3;           assign a_rt[3] = rt3;
    assign a_st[0] = st0; assign a_st[1] = st1; assign a_st[2] = st2; assign a_st[3] = st3;
    assign a_bv[0] = {4'h0, bv0}; assign a_bv[1] = {4'h0, bv1};
    assign a_bv[2] = {4'h0, bv2}; assign a_bv[3] = bv3;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: plain arrays of register contents and busy flags per variant.
    logic [31:0] m_regs [NC][8];
    logic        m_busy [NC][8];

    function automatic logic [2:0] amask(input int c, input logic [2:0] a);
        return (AWC[c] == 3) ? a : {1'b0, a[1:0]};
    endfunction

    function automatic logic [31:0] dmask(input int c, input logic [31:0] v);
        return (DWC[c] == 32) ? v : {16'h0, v[15:0]};
    endfunction

    function automatic logic forwarded(input int c, input logic [2:0] a);
        return BC[c] != 0 && we && !reset && amask(c, rd) == amask(c, a);
    endfunction

    function automatic logic [31:0] exp_read(input int c, input logic [2:0] a);
        if (ZC[c] != 0 && amask(c, a) == 3'd0) return 32'h0;
        if (forwarded(c, a)) return dmask(c, wd);
        return m_regs[c][amask(c, a)];
    endfunction

    function automatic logic exp_pending(input int c, input logic [2:0] a);
        return m_busy[c][amask(c, a)] && !forwarded(c, a);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NC; c++)
            for (int i = 0; i < 8; i++) begin
                m_regs[c][i] = 32'h0;
                m_busy[c][i] = 1'b0;
            end
    endtask

    task automatic model_edge();
        if (reset) return;
        for (int c = 0; c < NC; c++) begin
            if (we && !(ZC[c] != 0 && amask(c, rd) == 3'd0)) begin
                m_regs[c][amask(c, rd)] = dmask(c, wd);
                m_busy[c][amask(c, rd)] = 1'b0;
            end
            if (res && !(ZC[c] != 0 && amask(c, ra) == 3'd0))
                m_busy[c][amask(c, ra)] = 1'b1;
        end
    endtask

    task automatic check_all(input string ctx);
        for (int c = 0; c < NC; c++) begin
            logic [7:0] eb;
            eb = 8'h0;
            for (int i = 0; i < (1 << AWC[c]); i++) eb[i] = m_busy[c][i];
            check($sformatf("%s v%0d ReadRS", ctx, c), a_rs[c], exp_read(c, rs));
            check($sformatf("%s v%0d ReadRT", ctx, c), a_rt[c], exp_read(c, rt));
            check($sformatf("%s v%0d Stall", ctx, c), 32'(a_st[c]),
                  32'(exp_pending(c, rs) | exp_pending(c, rt)));
            check($sformatf("%s v%0d BusyVec", ctx, c), 32'(a_bv[c]), 32'(eb));
        end
    endtask

    task automatic drive(input logic we_i, input logic [2:0] rd_i, input logic [31:0] wd_i,
                         input logic res_i, input logic [2:0] ra_i,
                         input logic [2:0] rs_i, input logic [2:0] rt_i);
        we = we_i; rd = rd_i; wd = wd_i; res = res_i; ra = ra_i; rs = rs_i; rt = rt_i;
    endtask

    // Called just after a falling edge with inputs already applied.
    task automatic step(input string ctx);
        #1 check_all({ctx, " pre"});
        @(posedge clock);
        model_edge();
        #1 check_all({ctx, " post"});
        @(negedge clock);
    endtask

    task automatic pulse_reset(input string ctx);
        #1 reset = 1'b1;
        #1 model_reset();
        check_all({ctx, " in-reset"});
        #1 reset = 1'b0;
        step({ctx, " after"});
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        #1 model_reset();
        check_all("reset");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Reset mid-run discards data and reservations
        drive(1, 2, 32'hABCD, 0, 0, 2, 3); step("wr R2");
        drive(0, 0, 0, 1, 3, 2, 3);        step("rsv R3");
        check("midrst ReadRS before", 32'(rs0), 32'hABCD);
        check("midrst BusyVec before", 32'(bv0), 32'h8);
        drive(0, 0, 0, 0, 0, 2, 3);
        pulse_reset("midrst");
        check("midrst ReadRS after", 32'(rs0), 32'h0);
        check("midrst BusyVec after", 32'(bv0), 32'h0);

        // Bypass vs no bypass on the same write
        drive(1, 1, 32'h1234, 0, 0, 1, 0); step("byp");
        check("nobyp ReadRS after edge", 32'(rs1), 32'h1234);

        // Scoreboard reserve then writeback
        drive(0, 0, 0, 1, 2, 0, 0); step("sb rsv");
        drive(0, 0, 0, 0, 0, 2, 0);
        #1 check("sb Stall", 32'(st0), 32'h1);
        check("sb BusyVec", 32'(bv0), 32'h4);
        step("sb hold");
        drive(1, 2, 32'h00FF, 0, 0, 2, 0);
        #1 check("sb wb Stall", 32'(st0), 32'h0);
        step("sb wb");
        check("sb wb BusyVec", 32'(bv0), 32'h0);

        // Same-cycle write and reserve to one register: reserve wins
        drive(1, 1, 32'h5555, 1, 1, 1, 0); step("coll");
        drive(0, 0, 0, 0, 0, 1, 0);
        #1 check("coll ReadRS", 32'(rs0), 32'h5555);
        check("coll Busy1", 32'(bv0[1]), 32'h1);
        check("coll Stall", 32'(st0), 32'h1);
        step("coll hold");

        // Hardwired zero R0
        drive(1, 0, 32'hFFFF, 1, 0, 0, 0); step("zero");
        drive(0, 0, 0, 0, 0, 0, 0);
        #1 check("zero ReadRS", 32'(rs2), 32'h0);
        check("zero Busy0", 32'(bv2[0]), 32'h0);
        check("zero Stall", 32'(st2), 32'h0);
        step("zero hold");

        // Wide variant: fill all eight registers, read back on both ports
        for (int i = 0; i < 8; i++) begin
            drive(1, 3'(i), 32'hA5A50000 + 32'(i), 0, 0, 0, 0);
            step("wide wr");
        end
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 0, 0, 3'(i), 3'((i + 3) % 8));
            #1 check($sformatf("wide rs R%0d", i), rs3, 32'hA5A50000 + 32'(i));
            check($sformatf("wide rt R%0d", (i + 3) % 8), rt3, 32'hA5A50000 + 32'((i + 3) % 8));
            step("wide rd");
        end

        // Randomised traffic with occasional mid-run resets
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom), 3'($urandom), $urandom, 1'($urandom), 3'($urandom),
                  3'($urandom), 3'($urandom));
            if ($urandom_range(0, 49) == 0) pulse_reset("rnd reset");
            else step("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
